// File: rtl/gpio_ctrl_pkg.sv
// rtl/gpio_ctrl_pkg.sv - register map, data width and register index decode for gpio_ctrl
package gpio_ctrl_pkg;

  localparam int REG_DATA_W = 32;

  localparam logic [4:0] ADDR_DATA_OUT   = 5'h00;
  localparam logic [4:0] ADDR_DIR        = 5'h04;
  localparam logic [4:0] ADDR_DATA_IN    = 5'h08;
  localparam logic [4:0] ADDR_RISE_EN    = 5'h0C;
  localparam logic [4:0] ADDR_FALL_EN    = 5'h10;
  localparam logic [4:0] ADDR_IRQ_STATUS = 5'h14;
  localparam logic [4:0] ADDR_DB_LIMIT   = 5'h18;

  typedef enum logic [2:0] {
    REG_DATA_OUT   = 3'd0,
    REG_DIR        = 3'd1,
    REG_DATA_IN    = 3'd2,
    REG_RISE_EN    = 3'd3,
    REG_FALL_EN    = 3'd4,
    REG_IRQ_STATUS = 3'd5,
    REG_DB_LIMIT   = 3'd6,
    REG_NONE       = 3'd7
  } reg_idx_e;

  // Word-aligned decode; byte-lane bits [1:0] are ignored.
  function automatic reg_idx_e decode_addr(input logic [4:0] addr);
    case ({addr[4:2], 2'b00})
      ADDR_DATA_OUT:   return REG_DATA_OUT;
      ADDR_DIR:        return REG_DIR;
      ADDR_DATA_IN:    return REG_DATA_IN;
      ADDR_RISE_EN:    return REG_RISE_EN;
      ADDR_FALL_EN:    return REG_FALL_EN;
      ADDR_IRQ_STATUS: return REG_IRQ_STATUS;
      ADDR_DB_LIMIT:   return REG_DB_LIMIT;
      default:         return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gpio_ctrl_debounce.sv
// rtl/gpio_ctrl_debounce.sv - per-pin debounce counter and stable register (gpio_debounce)
module gpio_debounce
  import gpio_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] limit,
  input  logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] stable
);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [WIDTH-1:0] stable_q;

  // A pin must disagree with its stable value for limit+1 consecutive cycles before it is accepted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (rst) begin
        cnt_q[i]    <= '0;
        stable_q[i] <= 1'b0;
      end else if (sync_in[i] != stable_q[i]) begin
        if (cnt_q[i] >= limit) begin
          stable_q[i] <= sync_in[i];
          cnt_q[i]    <= '0;
        end else if (cnt_q[i] != {CNT_W{1'b1}}) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_q[i] <= '0;
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - GPIO controller top; GPIO_DEBOUNCE_EN compiles in input debounce and DB_LIMIT
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DB_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_wr_en,
  input  logic                  reg_rd_en,
  input  logic [4:0]            reg_addr,
  input  logic [REG_DATA_W-1:0] reg_wdata,
  output logic [REG_DATA_W-1:0] reg_rdata,
  output logic                  reg_rvalid,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      data_out,
  output logic [WIDTH-1:0]      dir_ctrl,
  output logic [WIDTH-1:0]      irq_event,
  output logic                  irq
);

  if (WIDTH < 1 || WIDTH > REG_DATA_W) begin : g_bad_width
    $error("gpio_ctrl: WIDTH must be 1..32");
  end
  if (DB_CNT_W < 1 || DB_CNT_W > REG_DATA_W) begin : g_bad_db_cnt_w
    $error("gpio_ctrl: DB_CNT_W must be 1..32");
  end

  reg_idx_e              reg_idx;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH-1:0]      data_out_q, dir_q, rise_en_q, fall_en_q, status_q;
  logic [WIDTH-1:0]      sync1_q, sync2_q, stable, stable_d_q;
  logic [WIDTH-1:0]      edge_evt, status_clr;
  logic [REG_DATA_W-1:0] rd_data;
  logic [REG_DATA_W-1:0] rdata_q;
  logic                  rvalid_q, irq_q;
  logic                  unused_bits;

  assign reg_idx     = decode_addr(reg_addr);
  assign wdata       = reg_wdata[WIDTH-1:0];
  assign unused_bits = ^{reg_wdata, reg_addr[1:0]};

`ifdef GPIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] db_limit_q;

  gpio_debounce #(
    .WIDTH (WIDTH),
    .CNT_W (DB_CNT_W)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .limit   (db_limit_q),
    .sync_in (sync2_q),
    .stable  (stable)
  );
`else
  assign stable = sync2_q;
`endif

  // Writable control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      dir_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
`ifdef GPIO_DEBOUNCE_EN
      db_limit_q <= '0;
`endif
    end else if (reg_wr_en) begin
      case (reg_idx)
        REG_DATA_OUT: data_out_q <= wdata;
        REG_DIR:      dir_q      <= wdata;
        REG_RISE_EN:  rise_en_q  <= wdata;
        REG_FALL_EN:  fall_en_q  <= wdata;
`ifdef GPIO_DEBOUNCE_EN
        REG_DB_LIMIT: db_limit_q <= reg_wdata[DB_CNT_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  // Two-flop synchronizer plus the previous-cycle copy of the conditioned input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_d_q <= '0;
    end else begin
      sync1_q    <= data_in;
      sync2_q    <= sync1_q;
      stable_d_q <= stable;
    end
  end

  // Edge events only on input pins; the W1C mask applies before the set so a same-cycle event survives.
  assign edge_evt   = ~dir_q & ((stable & ~stable_d_q & rise_en_q) |
                                (~stable & stable_d_q & fall_en_q));
  assign status_clr = (reg_wr_en && reg_idx == REG_IRQ_STATUS) ? wdata : '0;

  // Sticky interrupt status and its registered OR.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= (status_q & ~status_clr) | edge_evt;
      irq_q    <= |status_q;
    end
  end

  // Read mux over current register state, so a same-cycle write is not yet visible.
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      REG_DATA_OUT:   rd_data[WIDTH-1:0] = data_out_q;
      REG_DIR:        rd_data[WIDTH-1:0] = dir_q;
      REG_DATA_IN:    rd_data[WIDTH-1:0] = stable;
      REG_RISE_EN:    rd_data[WIDTH-1:0] = rise_en_q;
      REG_FALL_EN:    rd_data[WIDTH-1:0] = fall_en_q;
      REG_IRQ_STATUS: rd_data[WIDTH-1:0] = status_q;
`ifdef GPIO_DEBOUNCE_EN
      REG_DB_LIMIT:   rd_data[DB_CNT_W-1:0] = db_limit_q;
`endif
      default: ;
    endcase
  end

  // One-cycle read response; data holds until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= reg_rd_en;
      if (reg_rd_en) rdata_q <= rd_data;
    end
  end

  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign data_out   = data_out_q;
  assign dir_ctrl   = dir_q;
  assign irq_event  = status_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - scoreboard bench for gpio_ctrl with a pin-history reference model
module tb_gpio_ctrl;

  localparam int W = 8;
`ifdef GPIO_DEBOUNCE_EN
  localparam int PIPE = 3;
`else
  localparam int PIPE = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          reg_wr_en, reg_rd_en;
  logic [4:0]    reg_addr;
  logic [31:0]   reg_wdata, reg_rdata;
  logic          reg_rvalid;
  logic [W-1:0]  data_in, data_out, dir_ctrl, irq_event;
  logic          irq;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  bit db_mode = 1'b0;
  logic [31:0] exp_q [$];

  gpio_ctrl #(.WIDTH(W), .DB_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .reg_rvalid(reg_rvalid), .data_in(data_in), .data_out(data_out),
    .dir_ctrl(dir_ctrl), .irq_event(irq_event), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: registers plus a history of sampled pin levels.
  logic [W-1:0] m_out = '0, m_dir = '0, m_rise = '0, m_fall = '0, m_stat = '0;
  logic [15:0]  m_db = '0;
  logic         m_irq = 1'b0, m_rvalid = 1'b0;
  logic [W-1:0] samp [0:3] = '{default: '0};
  logic [W-1:0] m_ev, m_clr;

  always_comb begin
    m_ev  = ~m_dir & ((samp[PIPE-1] & ~samp[PIPE] & m_rise) | (~samp[PIPE-1] & samp[PIPE] & m_fall));
    m_clr = '0;
    if (reg_wr_en && reg_addr[4:2] == 3'd5) m_clr = reg_wdata[W-1:0];
  end

  always @(posedge clk) begin
    if (rst) begin
      m_out <= '0; m_dir <= '0; m_rise <= '0; m_fall <= '0; m_stat <= '0;
      m_db <= '0; m_irq <= 1'b0; m_rvalid <= 1'b0;
      for (int i = 0; i < 4; i++) samp[i] <= '0;
    end else begin
      m_irq    <= |m_stat;
      m_rvalid <= reg_rd_en;
      m_stat   <= (m_stat & ~m_clr) | m_ev;
      if (reg_wr_en) begin
        case (reg_addr[4:2])
          3'd0: m_out  <= reg_wdata[W-1:0];
          3'd1: m_dir  <= reg_wdata[W-1:0];
          3'd3: m_rise <= reg_wdata[W-1:0];
          3'd4: m_fall <= reg_wdata[W-1:0];
`ifdef GPIO_DEBOUNCE_EN
          3'd6: m_db   <= reg_wdata[15:0];
`endif
          default: ;
        endcase
      end
      samp[0] <= data_in;
      for (int i = 1; i < 4; i++) samp[i] <= samp[i-1];
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] r;
    r = '0;
    case (a[4:2])
      3'd0: r[W-1:0] = m_out;
      3'd1: r[W-1:0] = m_dir;
      3'd2: r[W-1:0] = samp[PIPE-1];
      3'd3: r[W-1:0] = m_rise;
      3'd4: r[W-1:0] = m_fall;
      3'd5: r[W-1:0] = m_stat;
`ifdef GPIO_DEBOUNCE_EN
      3'd6: r[15:0] = m_db;
`endif
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pin outputs against the model, read data against the scoreboard queue.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("data_out", data_out, m_out);
      chk("dir_ctrl", dir_ctrl, m_dir);
      chk("rvalid", reg_rvalid, m_rvalid);
      if (!db_mode) begin
        chk("irq_event", irq_event, m_stat);
        chk("irq", irq, m_irq);
      end
      if (reg_rvalid) begin
        if (exp_q.size() == 0) chk("rdata_unexpected", 1, 0);
        else chk("rdata", reg_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_wr_en = 1'b1;
    @(negedge clk);
    reg_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input bit use_model, input logic [31:0] exp);
    reg_addr = a; reg_rd_en = 1'b1;
    exp_q.push_back(use_model ? model_read(a) : exp);
    @(negedge clk);
    reg_rd_en = 1'b0;
  endtask

  initial begin
    logic [4:0]  a;
    logic [31:0] wd;
    int          op;
    rst = 1'b1; reg_wr_en = 1'b0; reg_rd_en = 1'b0;
    reg_addr = '0; reg_wdata = '0; data_in = '0;
    tick(3);
    mon_en = 1'b1;
    rst = 1'b0;

    // Reset values.
    chk("rst_dir", dir_ctrl, 0);
    chk("rst_irq", irq, 0);
    for (int i = 0; i < 8; i++) rd(5'(i * 4), 1'b0, 32'h0);

    // Output drive.
    wr(5'h04, 32'hFF);
    wr(5'h00, 32'hFFFF_FFA5);
    chk("drive_data_out", data_out, 32'hA5);
    chk("drive_dir", dir_ctrl, 32'hFF);
    rd(5'h00, 1'b0, 32'hA5);

    // Rising edge on pin 0: status after 3 edges, irq after 4, then W1C.
    wr(5'h04, 32'h0);
    wr(5'h0C, 32'h01);
    tick(4);
    data_in[0] = 1'b1;
    tick(2);
    chk("rise_not_yet", irq_event, 32'h0);
    tick(1);
    chk("rise_status", irq_event, 32'h01);
    chk("rise_irq_lag", irq, 0);
    tick(1);
    chk("rise_irq", irq, 1);
    wr(5'h14, 32'h01);
    chk("w1c_status", irq_event, 32'h0);
    tick(1);
    chk("w1c_irq", irq, 0);

    // Output pins never set status; clearing DIR re-enables detection.
    wr(5'h10, 32'h80);
    wr(5'h04, 32'h80);
    data_in[7] = 1'b1; tick(4);
    data_in[7] = 1'b0; tick(4);
    data_in[7] = 1'b1; tick(4);
    chk("mask_output_pin", irq_event, 32'h0);
    wr(5'h04, 32'h00);
    tick(2);
    data_in[7] = 1'b0;
    tick(4);
    chk("mask_fall_input", irq_event, 32'h80);

    // Set wins over a same-cycle W1C on pin 2.
    wr(5'h0C, 32'h05);
    wr(5'h10, 32'h84);
    wr(5'h14, 32'hFF);
    data_in[2] = 1'b1; tick(4);
    chk("pin2_rise", irq_event[2], 1);
    data_in[2] = 1'b0;
    tick(2);
    wr(5'h14, 32'h04);
    chk("set_beats_clear", irq_event[2], 1);
    wr(5'h14, 32'h04);
    chk("clear_after", irq_event[2], 0);

    // Read coincident with reset is dropped.
    reg_addr = 5'h00; reg_rd_en = 1'b1; rst = 1'b1;
    tick(1);
    reg_rd_en = 1'b0; rst = 1'b0;
    chk("rst_drops_read", reg_rvalid, 0);

    // Randomized traffic, including same-cycle read/write and occasional reset.
    for (int n = 0; n < 1500; n++) begin
      op = $urandom_range(0, 15);
      a  = 5'($urandom);
      wd = $urandom;
`ifdef GPIO_DEBOUNCE_EN
      if (a[4:2] == 3'd6) wd = '0;
`endif
      data_in   = data_in ^ (W'($urandom) & W'($urandom) & W'($urandom));
      rst       = (op == 15) && ($urandom_range(0, 7) == 0);
      reg_addr  = a;
      reg_wdata = wd;
      reg_wr_en = (op < 6);
      reg_rd_en = (op >= 4 && op < 11);
      if (reg_rd_en && !rst) exp_q.push_back(model_read(a));
      tick(1);
    end
    reg_wr_en = 1'b0; reg_rd_en = 1'b0; rst = 1'b0;
    tick(3);

`ifdef GPIO_DEBOUNCE_EN
    // Debounce: short glitch filtered, held level accepted.
    db_mode = 1'b1;
    rst = 1'b1; data_in = '0; tick(2); rst = 1'b0;
    wr(5'h18, 32'h4);
    rd(5'h18, 1'b0, 32'h4);
    wr(5'h0C, 32'h02);
    tick(8);
    data_in[1] = 1'b1; tick(3);
    data_in[1] = 1'b0; tick(10);
    rd(5'h08, 1'b0, 32'h0);
    chk("db_glitch_irq", irq, 0);
    chk("db_glitch_status", irq_event, 32'h0);
    data_in[1] = 1'b1; tick(12);
    rd(5'h08, 1'b0, 32'h02);
    tick(3);
    chk("db_held_status", irq_event, 32'h02);
`else
    rd(5'h18, 1'b0, 32'h0);
`endif

    tick(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Register-programmed controller for the GPIO pad bank that drives the CTRL side of the GPIO interface. It holds output data and per-pin direction, synchronizes and optionally debounces pin input, detects rising/falling edges on input pins, and latches sticky per-pin interrupt status with a combined interrupt line. It sits between the AXI-Lite slave's register strobe bus and the tri-state pad logic.

## Interface
Parameters:
- WIDTH, 8, number of GPIO pins (1..32)
- DB_CNT_W, 16, debounce counter width (used only with debounce compiled in)

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- reg_wr_en  input  1  write strobe, one cycle per write
- reg_rd_en  input  1  read strobe, one cycle per read
- reg_addr  input  5  byte address, bits [1:0] ignored
- reg_wdata  input  32  write data, bits above WIDTH ignored
- reg_rdata  output  32  read data, valid when reg_rvalid=1
- reg_rvalid  output  1  read-data valid pulse
- data_in  input  WIDTH  raw pin levels (asynchronous)
- data_out  output  WIDTH  pin output values
- dir_ctrl  output  WIDTH  1 = output, 0 = input
- irq_event  output  WIDTH  sticky per-pin interrupt status
- irq  output  1  OR of irq_event, registered

## Operation
- Register map:
  - 0x00 DATA_OUT RW
  - 0x04 DIR RW
  - 0x08 DATA_IN RO (conditioned input)
  - 0x0C RISE_EN RW
  - 0x10 FALL_EN RW
  - 0x14 IRQ_STATUS RO / W1C
  - 0x18 DB_LIMIT RW (debounce build only)
- Unmapped address: read returns 0, write ignored.
- Reads have no side effects; upper unused bits read 0.
- Input path: 2-flop synchronizer → conditioned value `stable` (equals synchronizer output when debounce is absent). Previous-cycle copy `stable_d` feeds edge detection.
- Edge detect per pin i, input pins only (dir_ctrl[i]=0):
  - rise = stable & ~stable_d & RISE_EN
  - fall = ~stable & stable_d & FALL_EN
  - Either sets IRQ_STATUS[i].
- Output pins never set status; existing status bits are kept when a pin's direction changes.
- W1C: writing 1 to IRQ_STATUS bit i clears it; writing 0 has no effect. If set and clear hit the same bit in the same cycle, set wins.
- irq = |IRQ_STATUS, registered.
- Simultaneous read and write in one cycle: both execute; read returns the pre-write value.

## Timing
- Reset: all registers, synchronizer flops, `stable`, `stable_d`, and counters go to 0. data_out=0, dir_ctrl=0 (all pins input), irq_event=0, irq=0, reg_rdata=0, reg_rvalid=0.
- Reset asserted mid-operation clears everything on the next edge; a pending read is dropped and reg_rvalid stays 0.
- Write takes effect at the clock edge where reg_wr_en=1. data_out/dir_ctrl show the new value the following cycle.
- Read latency is 1. reg_rvalid pulses for one cycle on the edge after reg_rd_en; reg_rdata holds its value until the next read.
- Pin-to-status latency without debounce: a pin change captured at edge k appears in DATA_IN after k+1, sets IRQ_STATUS at k+2, and raises irq at k+3.
- Back-to-back strobes: one access per cycle is allowed, with no stalls.

## Configuration
- Macro: GPIO_DEBOUNCE_EN.
- With the macro defined:
  - Each pin has a DB_CNT_W-bit counter.
  - While synchronizer output ≠ `stable`, the counter increments each cycle. When the counter reaches DB_LIMIT, `stable` takes the new value and the counter clears.
  - Any cycle with synchronizer output = `stable` clears the counter.
  - DB_LIMIT=0 adds exactly 1 cycle of latency.
  - The counter saturates rather than wrapping.
- Without the macro: `stable` = synchronizer output, 0x18 reads 0 and writes are ignored, and no counters are instantiated.

## Structure
- Package gpio_ctrl_pkg holds:
  - register address localparams (ADDR_DATA_OUT … ADDR_DB_LIMIT)
  - REG_DATA_W = 32
  - a typedef enum of register indices
- One sub-module, gpio_debounce: per-pin counter and stable register, WIDTH-vectorized. Instantiated only under GPIO_DEBOUNCE_EN.

## Test plan
- Reset: after reset, read every register → all 0; dir_ctrl=0, irq=0; reg_rvalid pulses 1 cycle after each read.
- Output drive: write DIR=0xFF, DATA_OUT=0xA5 → dir_ctrl=0xFF and data_out=0xA5 next cycle; reading DATA_OUT returns 0xA5.
- Rising edge: RISE_EN=0x01, DIR=0, raise data_in[0] → IRQ_STATUS=0x01 3 edges later, irq at 4. Write 0x14←0x01 → status 0 and irq 0 one cycle later.
- Masking: FALL_EN=0x80 with DIR[7]=1, toggle data_in[7] → no status. Clear DIR[7] and drop the pin → IRQ_STATUS[7]=1.
- Set vs clear: an edge event on pin 2 in the same cycle as a W1C of 0x04 → bit 2 remains 1.
- Debounce (GPIO_DEBOUNCE_EN): DB_LIMIT=4, 3-cycle glitch on pin 1 → DATA_IN unchanged and no irq. A level held ≥6 cycles → DATA_IN[1] updates.
